// File: rtl/xbus_decoder_pkg.sv
// Shared definitions for the xbus data-address decoder: FSM state encoding,
// default bus widths and the standard trap select value.
package xbus_decoder_pkg;

  localparam int XBUS_N_SLV      = 4;
  localparam int XBUS_DATA_W     = 32;
  localparam int XBUS_SEL_ADDR_W = 4;

  // Select value that raises a trap instead of reaching a slave
  localparam logic [XBUS_SEL_ADDR_W-1:0] XBUS_TRAP_BASE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } xbus_state_e;

endpackage

// File: rtl/xbus_decoder_if.sv
// Controller-side request/response bus plus the decoded slave channels.
// "slave" is the decoder's view; "master" is the controller/slave-array view.
interface xbus_decoder_if
  import xbus_decoder_pkg::*;
#(
  parameter int N_SLV      = XBUS_N_SLV,
  parameter int DATA_W     = XBUS_DATA_W,
  parameter int SEL_ADDR_W = XBUS_SEL_ADDR_W
);

  logic                    req_valid;
  logic [SEL_ADDR_W-1:0]   req_addr;
  logic                    req_ready;
  logic                    rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic                    rsp_err;
  logic [SEL_ADDR_W-1:0]   err_addr;
  logic                    trap;
  logic [N_SLV-1:0]        slv_sel;
  logic [N_SLV-1:0]        slv_ready;
  logic [N_SLV*DATA_W-1:0] slv_rdata;

  modport slave (
    input  req_valid, req_addr, slv_ready, slv_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_err, err_addr, trap, slv_sel
  );

  modport master (
    output req_valid, req_addr, slv_ready, slv_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err, err_addr, trap, slv_sel
  );

endinterface

// File: rtl/xbus_sel_enc.sv
// Combinational select encoder: compares an address select field against
// every slave base and returns hit, a one-hot match and the binary index.
// When several bases match, the lowest slave index wins.
module xbus_sel_enc #(
  parameter int N_SLV      = 4,
  parameter int SEL_ADDR_W = 4,
  parameter int IDX_W      = (N_SLV > 1) ? $clog2(N_SLV) : 1
) (
  input  logic [SEL_ADDR_W-1:0]       addr,
  input  logic [N_SLV*SEL_ADDR_W-1:0] slv_base,
  output logic                        hit,
  output logic [N_SLV-1:0]            match,
  output logic [IDX_W-1:0]            idx
);

  // Scan from the top index down so the last (lowest) match overrides
  always_comb begin
    hit   = 1'b0;
    match = '0;
    idx   = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (slv_base[i*SEL_ADDR_W +: SEL_ADDR_W] == addr) begin
        hit      = 1'b1;
        match    = '0;
        match[i] = 1'b1;
        idx      = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/xbus_decoder.sv
// Registered data-address decoder. Routes a controller access to one of
// N_SLV slaves (one-hot select held until that slave is ready), raises a
// one-cycle trap on TRAP_BASE, and answers unmapped selects with an error
// response while capturing the offending address in sticky err_addr.
// Optional build macro XBUS_TIMEOUT_EN: aborts an access with an error
// after TIMEOUT cycles without the selected slave becoming ready.
module xbus_decoder
  import xbus_decoder_pkg::*;
#(
  parameter int                              N_SLV      = XBUS_N_SLV,
  parameter int                              DATA_W     = XBUS_DATA_W,
  parameter int                              SEL_ADDR_W = XBUS_SEL_ADDR_W,
  parameter logic [N_SLV*SEL_ADDR_W-1:0]     SLV_BASE   = {4'd3, 4'd2, 4'd1, 4'd0},
  parameter logic [SEL_ADDR_W-1:0]           TRAP_BASE  = XBUS_TRAP_BASE,
  parameter int                              TIMEOUT_W  = 8,
  parameter int                              TIMEOUT    = 255
) (
  input logic           clk,
  input logic           rst,
  xbus_decoder_if.slave bus
);

  localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  xbus_state_e           state_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic [DATA_W-1:0]     rsp_data_q;
  logic                  rsp_err_q;
  logic [SEL_ADDR_W-1:0] err_addr_q;
  logic                  trap_q;
  logic [N_SLV-1:0]      slv_sel_q;
  logic [SEL_ADDR_W-1:0] addr_q;
  logic [IDX_W-1:0]      sel_idx_q;

  logic                  dec_hit;
  logic [N_SLV-1:0]      dec_match;
  logic [IDX_W-1:0]      dec_idx;
  logic                  ready_sel;
  logic [DATA_W-1:0]     rdata_sel;

`ifdef XBUS_TIMEOUT_EN
  logic [TIMEOUT_W-1:0]  tmo_cnt;
`else
  logic                  unused_cfg;
  assign unused_cfg = ^{addr_q, 32'(TIMEOUT), 32'(TIMEOUT_W)};
`endif

  xbus_sel_enc #(
    .N_SLV      (N_SLV),
    .SEL_ADDR_W (SEL_ADDR_W),
    .IDX_W      (IDX_W)
  ) u_sel_enc (
    .addr     (bus.req_addr),
    .slv_base (SLV_BASE),
    .hit      (dec_hit),
    .match    (dec_match),
    .idx      (dec_idx)
  );

  // Pick ready and read data of the latched slave only; others are ignored
  always_comb begin
    ready_sel = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (sel_idx_q == IDX_W'(i)) begin
        ready_sel = bus.slv_ready[i];
        rdata_sel = bus.slv_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Decoder FSM with registered outputs: IDLE -> (ACCESS) -> RESP -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      err_addr_q  <= '0;
      trap_q      <= 1'b0;
      slv_sel_q   <= '0;
`ifdef XBUS_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      trap_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            addr_q      <= bus.req_addr;
            req_ready_q <= 1'b0;
            if (dec_hit) begin
              state_q   <= ST_ACCESS;
              slv_sel_q <= dec_match;
              sel_idx_q <= dec_idx;
`ifdef XBUS_TIMEOUT_EN
              tmo_cnt   <= '0;
`endif
            end else begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              if (bus.req_addr == TRAP_BASE) begin
                trap_q    <= 1'b1;
                rsp_err_q <= 1'b0;
              end else begin
                rsp_err_q  <= 1'b1;
                err_addr_q <= bus.req_addr;
              end
            end
          end
        end
        ST_ACCESS: begin
          if (ready_sel) begin
            slv_sel_q   <= '0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rdata_sel;
            rsp_err_q   <= 1'b0;
            state_q     <= ST_RESP;
          end
`ifdef XBUS_TIMEOUT_EN
          else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt == TIMEOUT_W'(TIMEOUT - 1)) begin
              slv_sel_q   <= '0;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b1;
              err_addr_q  <= addr_q;
              state_q     <= ST_RESP;
            end
          end
`endif
        end
        ST_RESP: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          slv_sel_q   <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.err_addr  = err_addr_q;
  assign bus.trap      = trap_q;
  assign bus.slv_sel   = slv_sel_q;

endmodule

// File: tb/tb_xbus_decoder.sv
// Directed bench for xbus_decoder: table of single transactions plus
// hand-written reset-during-access and encoder-priority sequences.
// Build with +define+XBUS_TIMEOUT_EN to add the timeout vectors.
module tb_xbus_decoder;
  import xbus_decoder_pkg::*;

  localparam int N_SLV      = 4;
  localparam int DATA_W     = 32;
  localparam int SEL_ADDR_W = 4;

  typedef struct {
    logic [3:0]  addr;
    int          tgt;       // slave that will raise ready, -1 for none
    int          wt;        // ACCESS cycle (0-based) in which ready is raised
    bit          noise;     // pulse ready[3] in ACCESS cycle 1
    logic [3:0]  sel;       // expected OR of all slv_sel values seen
    int          sel_cyc;   // expected cycles with slv_sel non-zero
    int          rsp_c;     // expected cycle index of rsp_valid after request edge
    logic [31:0] data;
    bit          err;
    logic [3:0]  eaddr;
    int          trap_cyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  xbus_decoder_if #(.N_SLV(N_SLV), .DATA_W(DATA_W), .SEL_ADDR_W(SEL_ADDR_W)) bus ();

  xbus_decoder #(
    .N_SLV      (N_SLV),
    .DATA_W     (DATA_W),
    .SEL_ADDR_W (SEL_ADDR_W),
    .SLV_BASE   (16'h3210),
    .TRAP_BASE  (4'hF),
    .TIMEOUT_W  (8),
    .TIMEOUT    (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stand-alone encoder with overlapping bases to exercise priority
  logic [3:0] pe_addr;
  logic       pe_hit;
  logic [3:0] pe_match;
  logic [1:0] pe_idx;

  xbus_sel_enc #(.N_SLV(4), .SEL_ADDR_W(4), .IDX_W(2)) u_pe (
    .addr     (pe_addr),
    .slv_base (16'h5656),
    .hit      (pe_hit),
    .match    (pe_match),
    .idx      (pe_idx)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int         sel_cyc;
    int         trap_cyc;
    bit         seen;
    logic [3:0] sel_or;
    sel_cyc  = 0;
    trap_cyc = 0;
    seen     = 1'b0;
    sel_or   = '0;
    bus.req_valid = 1'b1;
    bus.req_addr  = v.addr;
    tick();
    bus.req_valid = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (bus.slv_sel != 4'b0) sel_cyc++;
      sel_or = sel_or | bus.slv_sel;
      if (bus.trap) trap_cyc++;
      if (bus.rsp_valid) begin
        seen = 1'b1;
        chk($sformatf("v%0d rsp_cycle", n), 64'(c), 64'(v.rsp_c));
        chk($sformatf("v%0d rsp_data", n), 64'(bus.rsp_data), 64'(v.data));
        chk($sformatf("v%0d rsp_err", n), 64'(bus.rsp_err), 64'(v.err));
        chk($sformatf("v%0d err_addr", n), 64'(bus.err_addr), 64'(v.eaddr));
        chk($sformatf("v%0d ready_in_resp", n), 64'(bus.req_ready), 64'(0));
        // a request during RESP must be ignored
        bus.slv_ready = '0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 4'hA;
        tick();
        bus.req_valid = 1'b0;
        if (bus.trap) trap_cyc++;
        if (bus.slv_sel != 4'b0) sel_cyc++;
        chk($sformatf("v%0d rsp_one_cycle", n), 64'(bus.rsp_valid), 64'(0));
        chk($sformatf("v%0d ready_after", n), 64'(bus.req_ready), 64'(1));
        chk($sformatf("v%0d data_hold", n), 64'(bus.rsp_data), 64'(v.data));
        chk($sformatf("v%0d err_addr_hold", n), 64'(bus.err_addr), 64'(v.eaddr));
      end else begin
        bus.slv_ready = '0;
        if (v.tgt >= 0 && c == v.wt) bus.slv_ready[v.tgt] = 1'b1;
        if (v.noise && c == 1) bus.slv_ready[3] = 1'b1;
        tick();
      end
    end
    bus.slv_ready = '0;
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL v%0d rsp_timeout: got no rsp_valid expected one within 40 cycles", n);
    end
    chk($sformatf("v%0d sel_cycles", n), 64'(sel_cyc), 64'(v.sel_cyc));
    chk($sformatf("v%0d sel_value", n), 64'(sel_or), 64'(v.sel));
    chk($sformatf("v%0d trap_cycles", n), 64'(trap_cyc), 64'(v.trap_cyc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    int   rv_bad;

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.slv_ready = '0;
    bus.slv_rdata = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
    pe_addr       = '0;

    //                addr  tgt wt noise sel      cyc rsp data          err eaddr trap
    vt.push_back(vec_t'{4'h2,  2, 0, 1'b0, 4'b0100, 1,  1, 32'hCAFE0002, 1'b0, 4'h0, 0});
    vt.push_back(vec_t'{4'h1,  1, 5, 1'b1, 4'b0010, 6,  6, 32'hCAFE0001, 1'b0, 4'h0, 0});
    vt.push_back(vec_t'{4'hF, -1, 0, 1'b0, 4'b0000, 0,  0, 32'h00000000, 1'b0, 4'h0, 1});
    vt.push_back(vec_t'{4'h9, -1, 0, 1'b0, 4'b0000, 0,  0, 32'h00000000, 1'b1, 4'h9, 0});
    vt.push_back(vec_t'{4'h0,  0, 2, 1'b0, 4'b0001, 3,  3, 32'hCAFE0000, 1'b0, 4'h9, 0});
    vt.push_back(vec_t'{4'h3,  3, 1, 1'b0, 4'b1000, 2,  2, 32'hCAFE0003, 1'b0, 4'h9, 0});
    vt.push_back(vec_t'{4'h5, -1, 0, 1'b0, 4'b0000, 0,  0, 32'h00000000, 1'b1, 4'h5, 0});
`ifdef XBUS_TIMEOUT_EN
    vt.push_back(vec_t'{4'h2,  2, 99, 1'b0, 4'b0100, 10, 10, 32'h00000000, 1'b1, 4'h2, 0});
    vt.push_back(vec_t'{4'h2,  2, 9,  1'b0, 4'b0100, 10, 10, 32'hCAFE0002, 1'b0, 4'h2, 0});
`endif

    tick();
    tick();
    rst = 1'b0;
    chk("reset req_ready", 64'(bus.req_ready), 64'(1));
    chk("reset rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("reset rsp_data", 64'(bus.rsp_data), 64'(0));
    chk("reset rsp_err", 64'(bus.rsp_err), 64'(0));
    chk("reset err_addr", 64'(bus.err_addr), 64'(0));
    chk("reset trap", 64'(bus.trap), 64'(0));
    chk("reset slv_sel", 64'(bus.slv_sel), 64'(0));

    // Encoder priority with bases {5,6,5,6}
    pe_addr = 4'h6;
    #1;
    chk("enc addr6 match", 64'(pe_match), 64'(4'b0001));
    chk("enc addr6 idx", 64'(pe_idx), 64'(0));
    pe_addr = 4'h5;
    #1;
    chk("enc addr5 match", 64'(pe_match), 64'(4'b0010));
    chk("enc addr5 idx", 64'(pe_idx), 64'(1));
    chk("enc addr5 hit", 64'(pe_hit), 64'(1));
    pe_addr = 4'h7;
    #1;
    chk("enc addr7 hit", 64'(pe_hit), 64'(0));
    chk("enc addr7 match", 64'(pe_match), 64'(0));

    for (int i = 0; i < vt.size(); i++) run_vec(i, vt[i]);

    // Reset while an access is in flight
    bus.req_valid = 1'b1;
    bus.req_addr  = 4'h1;
    tick();
    bus.req_valid = 1'b0;
    chk("rst_acc sel_before", 64'(bus.slv_sel), 64'(4'b0010));
    chk("rst_acc ready_before", 64'(bus.req_ready), 64'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_acc slv_sel", 64'(bus.slv_sel), 64'(0));
    chk("rst_acc req_ready", 64'(bus.req_ready), 64'(1));
    chk("rst_acc rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_acc err_addr", 64'(bus.err_addr), 64'(0));
    bus.slv_ready = 4'b0010;
    rv_bad = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.rsp_valid || bus.slv_sel != 4'b0) rv_bad++;
    end
    bus.slv_ready = '0;
    chk("rst_acc dropped", 64'(rv_bad), 64'(0));
    run_vec(100, vec_t'{4'h2, 2, 0, 1'b0, 4'b0100, 1, 1, 32'hCAFE0002, 1'b0, 4'h0, 0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
